capture_trigger_ctrl: RTL and testbench

Acquisition front end that sits directly upstream of the sample-buffer dual-port RAM: takes the ADC sample stream, writes it circularly into the RAM write port, detects a level/edge trigger, and stops after a programmed post-trigger depth. On completion it reports the trigger address and the oldest-sample address so the display/readout side can unroll the circular buffer through the RAM read port. One capture fills exactly 2**ADDR_WIDTH samples.

---
 rtl/capture_pkg.sv | 17 +
 rtl/capture_trigger_ctrl_if.sv | 47 ++++
 rtl/trigger_detect.sv | 67 ++++++
 rtl/capture_trigger_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_capture_trigger_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/capture_pkg.sv
// Shared types and default widths for the capture/trigger front end.
// Optional feature macro: CAPTURE_DECIMATION_EN (adds an 8-bit decim input).
package capture_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned ADDR_WIDTH_DEF = 14;
    localparam int unsigned DECIM_WIDTH    = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRETRIG   = 3'd1,
        WAIT_TRIG = 3'd2,
        POSTTRIG  = 3'd3,
        DONE      = 3'd4
    } state_e;

endpackage

// File: rtl/capture_trigger_ctrl_if.sv
// Bus bundle between the acquisition controller and its surroundings:
// ADC stream, control/config inputs, RAM write port and capture status.
// Optional feature macro: CAPTURE_DECIMATION_EN (adds decim).
interface capture_trigger_ctrl_if
    import capture_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);

    logic [DATA_WIDTH-1:0]  adc_data;
    logic                   adc_valid;
    logic                   arm;
    logic                   force_trig;
    logic [DATA_WIDTH-1:0]  trig_level;
    logic                   trig_falling;
    logic [ADDR_WIDTH-1:0]  pre_trig_len;
`ifdef CAPTURE_DECIMATION_EN
    logic [DECIM_WIDTH-1:0] decim;
`endif
    logic [DATA_WIDTH-1:0]  wdata;
    logic [ADDR_WIDTH-1:0]  waddr;
    logic                   we;
    logic                   busy;
    logic                   done;
    logic [ADDR_WIDTH-1:0]  trig_addr;
    logic [ADDR_WIDTH-1:0]  start_addr;

    // Controller side
    modport slave (
        input  adc_data, adc_valid, arm, force_trig, trig_level, trig_falling, pre_trig_len,
`ifdef CAPTURE_DECIMATION_EN
        input  decim,
`endif
        output wdata, waddr, we, busy, done, trig_addr, start_addr
    );

    // Source / system side
    modport master (
        output adc_data, adc_valid, arm, force_trig, trig_level, trig_falling, pre_trig_len,
`ifdef CAPTURE_DECIMATION_EN
        output decim,
`endif
        input  wdata, waddr, we, busy, done, trig_addr, start_addr
    );

endinterface

// File: rtl/trigger_detect.sv
// Trigger qualifier: remembers the previous accepted sample, evaluates the
// rising/falling threshold crossing and holds a software trigger pending
// until the next accepted sample.
module trigger_detect #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  sample_acc,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic [DATA_WIDTH-1:0] level,
    input  logic                  falling,
    input  logic                  force_trig,
    output logic                  trig_hit
);

    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                  prev_valid_q, prev_valid_d;
    logic                  force_pend_q, force_pend_d;
    logic                  edge_c;

    // Crossing compare, hit decision and next-state of the history registers
    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        force_pend_d = force_pend_q;

        if (falling) begin
            edge_c = prev_valid_q && (prev_q > level) && (sample <= level);
        end else begin
            edge_c = prev_valid_q && (prev_q < level) && (sample >= level);
        end

        trig_hit = enable && sample_acc && (edge_c || force_trig || force_pend_q);

        if (clear) begin
            prev_valid_d = 1'b0;
            force_pend_d = 1'b0;
        end else begin
            if (sample_acc) begin
                prev_d       = sample;
                prev_valid_d = 1'b1;
            end
            if (!enable || trig_hit) begin
                force_pend_d = 1'b0;
            end else if (force_trig) begin
                force_pend_d = 1'b1;
            end
        end
    end

    // History registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            force_pend_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            force_pend_q <= force_pend_d;
        end
    end

endmodule

// File: rtl/capture_trigger_ctrl.sv
// Circular-buffer capture controller: writes accepted ADC samples into the
// sample RAM, arms/triggers/stops, and reports trigger and oldest-sample
// addresses for unrolling the buffer.
// Optional feature macro: CAPTURE_DECIMATION_EN (accept every (decim+1)-th sample).
module capture_trigger_ctrl
    import capture_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    capture_trigger_ctrl_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    // Largest usable pre-trigger length; also the last post-count index base
    localparam logic [ADDR_WIDTH-1:0] PRE_MAX = ADDR_WIDTH'(DEPTH - 2);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
    logic [ADDR_WIDTH-1:0] pre_len_q, pre_len_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic                  arm_ok_c;
    logic                  sample_acc_c;
    logic                  wr_c;
    logic                  trig_hit_c;
    logic [ADDR_WIDTH-1:0] pre_clamp_c;
    logic [ADDR_WIDTH-1:0] wr_ptr_c;
    logic [ADDR_WIDTH-1:0] post_last_c;

    // Arm is honoured only when no capture is running
    assign arm_ok_c    = bus.arm && ((state_q == IDLE) || (state_q == DONE));
    assign pre_clamp_c = (bus.pre_trig_len > PRE_MAX) ? PRE_MAX : bus.pre_trig_len;
    // Address a write accepted this cycle lands on (pointer advances after each we pulse)
    assign wr_ptr_c    = waddr_q + ADDR_WIDTH'(we_q);
    // Post-trigger writes are DEPTH-1-pre; compare against count-1
    assign post_last_c = PRE_MAX - pre_len_q;

`ifdef CAPTURE_DECIMATION_EN
    logic [DECIM_WIDTH-1:0] dcnt_q, dcnt_d;

    assign sample_acc_c = bus.adc_valid && (dcnt_q == '0);

    // Decimation phase counter, restarted on arm so the first valid sample is kept
    always_comb begin
        dcnt_d = dcnt_q;
        if (arm_ok_c) begin
            dcnt_d = '0;
        end else if (bus.adc_valid) begin
            dcnt_d = (dcnt_q >= bus.decim) ? '0 : dcnt_q + DECIM_WIDTH'(1);
        end
    end

    // Decimation phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
        end
    end
`else
    assign sample_acc_c = bus.adc_valid;
`endif

    trigger_detect #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_trigger_detect (
        .clk        (clk),
        .rst        (rst),
        .enable     (state_q == WAIT_TRIG),
        .clear      (arm_ok_c),
        .sample_acc (sample_acc_c),
        .sample     (bus.adc_data),
        .level      (bus.trig_level),
        .falling    (bus.trig_falling),
        .force_trig (bus.force_trig),
        .trig_hit   (trig_hit_c)
    );

    // Capture sequencing, write-port generation and status
    always_comb begin
        state_d      = state_q;
        waddr_d      = wr_ptr_c;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        pre_len_d    = pre_len_q;
        cnt_d        = cnt_q;
        wr_c         = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                if (arm_ok_c) begin
                    pre_len_d = pre_clamp_c;
                    cnt_d     = '0;
                    waddr_d   = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    state_d   = (pre_clamp_c == '0) ? WAIT_TRIG : PRETRIG;
                end
            end
            PRETRIG: begin
                if (sample_acc_c) begin
                    wr_c = 1'b1;
                    if (cnt_q == pre_len_q - ADDR_WIDTH'(1)) begin
                        cnt_d   = '0;
                        state_d = WAIT_TRIG;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            WAIT_TRIG: begin
                if (sample_acc_c) begin
                    wr_c = 1'b1;
                    if (trig_hit_c) begin
                        trig_addr_d  = wr_ptr_c;
                        start_addr_d = wr_ptr_c - pre_len_q;
                        cnt_d        = '0;
                        state_d      = POSTTRIG;
                    end
                end
            end
            POSTTRIG: begin
                if (sample_acc_c) begin
                    wr_c = 1'b1;
                    if (cnt_q == post_last_c) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wr_c) begin
            we_d    = 1'b1;
            wdata_d = bus.adc_data;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            waddr_q      <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            pre_len_q    <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            pre_len_q    <= pre_len_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.wdata      = wdata_q;
    assign bus.waddr      = waddr_q;
    assign bus.we         = we_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.trig_addr  = trig_addr_q;
    assign bus.start_addr = start_addr_q;

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Directed bench for capture_trigger_ctrl at DEPTH=16: table of full captures
// plus hand sequences for force/arm/reset corner cases.
module tb_capture_trigger_ctrl;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int          DEPTH = 16;
    localparam int          NVEC  = 6;

    logic clk = 1'b0;
    logic rst;

    capture_trigger_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    capture_trigger_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pre;
        int          level;
        bit          fall;
        logic [15:0] head [4];
        int          head_n;
        int          start;
        int          step;
        int          force_at;
        int          et;
        int          es;
        int          ewe;
        int          ed;
    } vec_t;

    vec_t tbl [NVEC];

    int checks   = 0;
    int failures = 0;

    int            we_cnt;
    int            addr_err;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] mem [DEPTH];

    // Write-port observer: counts pulses, checks address sequence, shadows RAM
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            we_cnt = we_cnt + 1;
            if (bus.waddr !== exp_waddr) addr_err = addr_err + 1;
            mem[bus.waddr] = bus.wdata;
            exp_waddr = exp_waddr + 1'b1;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        we_cnt    = 0;
        addr_err  = 0;
        exp_waddr = '0;
    endtask

    task automatic arm_pulse();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic feed(input int data, input bit frc);
        bus.adc_valid  = 1'b1;
        bus.adc_data   = DW'(data);
        bus.force_trig = frc;
        tick();
        bus.adc_valid  = 1'b0;
        bus.force_trig = 1'b0;
    endtask

    function automatic vec_t mk(input int pre, input int level, input bit fall,
                                input int h0, input int h1, input int h2, input int h3,
                                input int hn, input int start, input int step,
                                input int force_at, input int et, input int es,
                                input int ewe, input int ed);
        vec_t v;
        v.pre = pre;   v.level = level;  v.fall = fall;
        v.head[0] = 16'(h0); v.head[1] = 16'(h1);
        v.head[2] = 16'(h2); v.head[3] = 16'(h3);
        v.head_n = hn; v.start = start; v.step = step; v.force_at = force_at;
        v.et = et; v.es = es; v.ewe = ewe; v.ed = ed;
        return v;
    endfunction

    function automatic int sample(input vec_t v, input int i);
        if (i < v.head_n) return int'(v.head[i]);
        return int'(DW'(v.start + (i - v.head_n) * v.step));
    endfunction

    task automatic run_vec(input int k);
        vec_t v;
        int   i;
        v = tbl[k];
        bus.pre_trig_len = AW'(v.pre);
        bus.trig_level   = DW'(v.level);
        bus.trig_falling = v.fall;
        clear_mon();
        arm_pulse();
        check($sformatf("v%0d_busy_after_arm", k), int'(bus.busy), 1);
        i = 0;
        while (bus.done !== 1'b1 && i < 100) begin
            feed(sample(v, i), (i == v.force_at));
            i++;
        end
        check($sformatf("v%0d_done_in_time", k), int'(bus.done === 1'b1), 1);
        check($sformatf("v%0d_trig_addr", k), int'(bus.trig_addr), v.et);
        check($sformatf("v%0d_start_addr", k), int'(bus.start_addr), v.es);
        check($sformatf("v%0d_we_count", k), we_cnt, v.ewe);
        check($sformatf("v%0d_addr_seq_err", k), addr_err, 0);
        check($sformatf("v%0d_trig_data", k), int'(mem[v.et]), v.ed);
        check($sformatf("v%0d_oldest_data", k), int'(mem[v.es]), sample(v, v.ewe - DEPTH));
        check($sformatf("v%0d_busy_done", k), int'(bus.busy), 0);
    endtask

    initial begin
        int i;
        //        pre lvl  fall head............  hn start step frc  et es we  data
        tbl[0] = mk(4,  100,  0,   0,  0,  0,  0, 0,   0,  10, -1, 10, 6, 22, 100);
        tbl[1] = mk(4,  100,  0,  90,110, 90, 80, 4,   0,  20, -1,  9, 5, 21, 100);
        tbl[2] = mk(0,   50,  1,  50, 40, 60, 50, 4,  60,   0, -1,  3, 3, 19,  50);
        tbl[3] = mk(3, 1000,  0,   0,  0,  0,  0, 0,   0,   1,  6,  6, 3, 19,   6);
        tbl[4] = mk(15,  20,  0,   0,  0,  0,  0, 0,   0,   1, -1,  4, 6, 22,  20);
        tbl[5] = mk(4,   50,  1,   0,  0,  0,  0, 0, 200, -10, -1, 15, 11, 27, 50);

        rst = 1'b1;
        bus.adc_data = '0;  bus.adc_valid = 1'b0; bus.arm = 1'b0; bus.force_trig = 1'b0;
        bus.trig_level = '0; bus.trig_falling = 1'b0; bus.pre_trig_len = '0;
`ifdef CAPTURE_DECIMATION_EN
        bus.decim = '0;
`endif
        clear_mon();
        repeat (2) tick();
        check("rst_we", int'(bus.we), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_waddr", int'(bus.waddr), 0);
        check("rst_wdata", int'(bus.wdata), 0);
        check("rst_trig_addr", int'(bus.trig_addr), 0);
        check("rst_start_addr", int'(bus.start_addr), 0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < NVEC; k++) run_vec(k);

        // Software trigger held pending across invalid cycles; arm while busy ignored
        bus.pre_trig_len = 4'd2; bus.trig_level = 16'd1000; bus.trig_falling = 1'b0;
        clear_mon();
        arm_pulse();
        feed(0, 1'b1);
        feed(1, 1'b0);
        feed(2, 1'b0);
        feed(3, 1'b0);
        bus.force_trig = 1'b1;
        tick();
        bus.force_trig = 1'b0;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        check("busy_arm_ignored", int'(bus.busy), 1);
        repeat (5) tick();
        feed(77, 1'b0);
        check("force_trig_addr", int'(bus.trig_addr), 4);
        check("force_start_addr", int'(bus.start_addr), 2);
        check("force_we", int'(bus.we), 1);
        check("force_waddr", int'(bus.waddr), 4);
        check("force_wdata", int'(bus.wdata), 77);
        i = 0;
        while (bus.done !== 1'b1 && i < 100) begin
            feed(100 + i, 1'b0);
            i++;
        end
        check("force_done_in_time", int'(bus.done === 1'b1), 1);
        check("force_we_count", we_cnt, 18);
        check("force_addr_seq_err", addr_err, 0);

        // Arm in DONE wins over a coincident trigger and restarts the buffer
        bus.pre_trig_len = 4'd0;
        clear_mon();
        bus.adc_valid = 1'b1; bus.adc_data = 16'd999; bus.force_trig = 1'b1; bus.arm = 1'b1;
        tick();
        bus.adc_valid = 1'b0; bus.force_trig = 1'b0; bus.arm = 1'b0;
        check("rearm_done", int'(bus.done), 0);
        check("rearm_busy", int'(bus.busy), 1);
        check("rearm_waddr", int'(bus.waddr), 0);
        check("rearm_we", int'(bus.we), 0);

        // Asynchronous reset in the middle of POSTTRIG
        feed(500, 1'b0);
        feed(501, 1'b0);
        feed(502, 1'b1);
        feed(503, 1'b0);
        feed(504, 1'b0);
        check("post_trig_addr", int'(bus.trig_addr), 2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_we", int'(bus.we), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_done", int'(bus.done), 0);
        check("arst_waddr", int'(bus.waddr), 0);
        check("arst_wdata", int'(bus.wdata), 0);
        check("arst_trig_addr", int'(bus.trig_addr), 0);
        check("arst_start_addr", int'(bus.start_addr), 0);
        we_cnt = 0;
        bus.adc_valid = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        bus.adc_valid = 1'b0;
        check("arst_no_writes", we_cnt, 0);
        check("arst_idle_busy", int'(bus.busy), 0);

`ifdef CAPTURE_DECIMATION_EN
        // Decimation by 3: one write per three valid samples
        bus.decim = 8'd2; bus.pre_trig_len = 4'd0; bus.trig_level = 16'd1000;
        clear_mon();
        arm_pulse();
        for (int j = 0; j < 9; j++) feed(j, 1'b0);
        tick();
        check("decim_we_count", we_cnt, 3);
        check("decim_addr_seq_err", addr_err, 0);
        check("decim_last_data", int'(mem[2]), 6);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
